sd_card_cmd_responder: RTL and testbench

//  Card-side endpoint of the SD CMD line, one SD clock domain.
//  - Receives 48-bit host command frames bit-serially.
//  - Decodes index and argument.
//  - Returns a 48-bit R1-format response through a tri-state enable.

---
 rtl/sd_card_cmd_responder.sv | 153 +++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands bit-serially,
// decodes index/argument, and answers with a 48-bit R1-format response.
// Optional feature macro: SD_CMD_CRC_CHECK_EN (reject commands with a bad CRC7).
module sd_card_cmd_responder #(
    parameter int unsigned RESP_DELAY = 2  // N_CR, legal range 2..64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_in,
    input  logic        resp_en,
    input  logic [31:0] resp_status,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err
);

    typedef enum logic [2:0] {StIdle, StRx, StCheck, StWait, StTx} state_t;

    localparam logic [6:0] WaitLast = 7'(RESP_DELAY - 1);

    state_t      state_q;
    logic [5:0]  bit_cnt_q;   // command bits received so far, start bit included
    logic [44:0] rx_sreg_q;   // last 45 bits received: ends up as frame bits 45..1
    logic [6:0]  crc_q;       // shared by RX check and TX generation
    logic        frame_ok_q;
    logic [39:0] tx_data_q;   // response bits 47..8, shifted out MSB first
    logic [6:0]  wait_cnt_q;
    logic [5:0]  tx_cnt_q;    // response bits already driven

    logic crc_match;
    logic frame_good;

    // One serial step of CRC7, generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // Valid while the end bit is on cmd_in: rx_sreg_q[6:0] holds the received CRC.
    assign crc_match = (crc_q == rx_sreg_q[6:0]);

`ifdef SD_CMD_CRC_CHECK_EN
    assign frame_good = crc_match;
`else
    logic unused_crc_match;
    assign frame_good       = 1'b1;
    assign unused_crc_match = crc_match;
    assign crc_err          = 1'b0;
`endif

    // Command receive / response transmit FSM with registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_sreg_q  <= '0;
            crc_q      <= '0;
            frame_ok_q <= 1'b0;
            tx_data_q  <= '0;
            wait_cnt_q <= '0;
            tx_cnt_q   <= '0;
            cmd_out    <= 1'b1;
            cmd_oe     <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
`ifdef SD_CMD_CRC_CHECK_EN
            crc_err    <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            crc_err   <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (!cmd_in) begin
                        state_q   <= StRx;
                        bit_cnt_q <= 6'd1;
                        crc_q     <= '0;  // CRC of the leading zero start bit is zero
                    end
                end
                StRx: begin
                    rx_sreg_q <= {rx_sreg_q[43:0], cmd_in};
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                    if (bit_cnt_q < 6'd40) begin
                        crc_q <= crc7_step(crc_q, cmd_in);
                    end
                    if (bit_cnt_q == 6'd1 && !cmd_in) begin
                        // Transmission bit 0: another card's response on the bus.
                        state_q <= StIdle;
                    end else if (bit_cnt_q == 6'd47) begin
                        if (!cmd_in) begin
                            state_q <= StIdle;  // framing error, silently dropped
                        end else begin
                            state_q    <= StCheck;
                            frame_ok_q <= frame_good;
                            cmd_valid  <= frame_good;
`ifdef SD_CMD_CRC_CHECK_EN
                            crc_err    <= !frame_good;
`endif
                            if (frame_good) begin
                                cmd_index <= rx_sreg_q[44:39];
                                cmd_arg   <= rx_sreg_q[38:7];
                            end
                        end
                    end
                end
                StCheck: begin
                    tx_data_q  <= {2'b00, cmd_index, resp_status};
                    wait_cnt_q <= '0;
                    state_q    <= (frame_ok_q && resp_en) ? StWait : StIdle;
                end
                StWait: begin
                    if (wait_cnt_q == WaitLast) begin
                        // Drive the start bit on the same edge that enters TX.
                        state_q   <= StTx;
                        cmd_oe    <= 1'b1;
                        cmd_out   <= tx_data_q[39];
                        crc_q     <= crc7_step(7'd0, tx_data_q[39]);
                        tx_data_q <= {tx_data_q[38:0], 1'b0};
                        tx_cnt_q  <= 6'd1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 7'd1;
                    end
                end
                StTx: begin
                    tx_cnt_q <= tx_cnt_q + 6'd1;
                    if (tx_cnt_q < 6'd40) begin
                        cmd_out   <= tx_data_q[39];
                        crc_q     <= crc7_step(crc_q, tx_data_q[39]);
                        tx_data_q <= {tx_data_q[38:0], 1'b0};
                    end else if (tx_cnt_q < 6'd47) begin
                        cmd_out <= crc_q[6];
                        crc_q   <= {crc_q[5:0], 1'b0};
                    end else if (tx_cnt_q == 6'd47) begin
                        cmd_out <= 1'b1;  // end bit
                    end else begin
                        cmd_oe  <= 1'b0;
                        cmd_out <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: a driver issues command frames and
// pushes expected pulses/responses; a monitor pops and compares as the DUT emits them.
module tb_sd_card_cmd_responder;

    localparam int unsigned RD = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        cmd_in = 1'b1;
    logic        resp_en = 1'b0;
    logic [31:0] resp_status = '0;
    logic        cmd_out, cmd_oe, cmd_valid, crc_err;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    sd_card_cmd_responder #(.RESP_DELAY(RD)) dut (
        .CLK(CLK), .RESET(RESET), .cmd_in(cmd_in), .resp_en(resp_en),
        .resp_status(resp_status), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
        .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .crc_err(crc_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          due;
    } ev_t;
    typedef struct {
        logic [47:0] bits;
        int          due;
    } rsp_t;

    ev_t  ev_q[$];
    rsp_t rsp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference CRC7 by polynomial long division of d * x^7 by x^7 + x^3 + 1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        d = {2'b01, idx, arg};
        return {d, ref_crc7(d), 1'b1};
    endfunction

    // Send a host command and record what the card must do with it.
    task automatic run_cmd(input logic [47:0] f, input bit ren, input logic [31:0] st,
                           input bit wait_done, output int end_n);
        bit   good;
        bit   tx;
        ev_t  e;
        rsp_t r;
        logic [39:0] rd;
        resp_en     = ren;
        resp_status = st;
        for (int i = 47; i >= 0; i--) begin
            @(negedge CLK) cmd_in = f[i];
        end
        end_n = cyc + 1;
`ifdef SD_CMD_CRC_CHECK_EN
        good = (f[7:1] == ref_crc7(f[47:8]));
`else
        good = 1'b1;
`endif
        e.is_err = !good;
        e.idx    = f[45:40];
        e.arg    = f[39:8];
        e.due    = end_n;
        ev_q.push_back(e);
        tx = good && ren;
        if (tx) begin
            rd     = {2'b00, f[45:40], st};
            r.bits = {rd, ref_crc7(rd), 1'b1};
            r.due  = end_n + 1 + RD;
            rsp_q.push_back(r);
        end
        if (wait_done) begin
            @(negedge CLK) cmd_in = 1'b1;
            // Status/enable change after CHECK must not affect the response.
            @(negedge CLK) begin
                resp_status = $urandom;
                resp_en     = 1'($urandom);
            end
            if (tx) repeat (RD + 47) @(negedge CLK);
        end
    endtask

    // Bits the card must ignore; nothing is expected from them.
    task automatic run_raw(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge CLK) cmd_in = f[i];
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse or a response.
    bit          collecting = 0;
    int          rcnt = 0;
    logic [47:0] rbits = '0;
    rsp_t        cur;
    ev_t         em;
    logic [5:0]  hold_idx = '0;
    logic [31:0] hold_arg = '0;

    always @(negedge CLK) begin
        if (!RESET) begin
            collecting = 0;
            rcnt       = 0;
            hold_idx   = '0;
            hold_arg   = '0;
        end else begin
            if (cmd_valid || crc_err) begin
                if (ev_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: valid=%b crc_err=%b, expected none (cycle %0d)",
                             cmd_valid, crc_err, cyc);
                end else begin
                    em = ev_q.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(em.due));
                    check("pulse_kind", {62'b0, cmd_valid, crc_err},
                          em.is_err ? 64'd1 : 64'd2);
                    if (!em.is_err) begin
                        hold_idx = em.idx;
                        hold_arg = em.arg;
                    end
                end
            end else if (ev_q.size() != 0 && ev_q[0].due < cyc) begin
                void'(ev_q.pop_front());
                n_total++;
                $display("FAIL missing_pulse: got none, expected one by cycle %0d", cyc - 1);
            end
            check("cmd_index", 64'(cmd_index), 64'(hold_idx));
            check("cmd_arg", 64'(cmd_arg), 64'(hold_arg));

            if (cmd_oe) begin
                if (!collecting) begin
                    collecting = 1;
                    rcnt       = 0;
                    if (rsp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_response: cmd_oe=1, expected 0 (cycle %0d)", cyc);
                        cur.bits = 'x;
                        cur.due  = cyc;
                    end else begin
                        cur = rsp_q.pop_front();
                        check("resp_start_cycle", 64'(cyc), 64'(cur.due));
                    end
                end
                rbits = {rbits[46:0], cmd_out};
                rcnt++;
                if (rcnt == 48) begin
                    check("resp_frame", 64'(rbits), 64'(cur.bits));
                    collecting = 0;
                end
            end else begin
                if (collecting) begin
                    n_total++;
                    $display("FAIL resp_length: got %0d bits, expected 48", rcnt);
                    collecting = 0;
                end
                check("idle_line", 64'(cmd_out), 64'd1);
                if (rsp_q.size() != 0 && rsp_q[0].due < cyc) begin
                    void'(rsp_q.pop_front());
                    n_total++;
                    $display("FAIL missing_response: got none, expected start by cycle %0d",
                             cyc - 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          target;
        logic [47:0] f;
        logic [6:0]  flip;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_cmd_out", 64'(cmd_out), 64'd1);
        check("rst_cmd_oe", 64'(cmd_oe), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_crc_err", 64'(crc_err), 64'd0);
        check("rst_cmd_index", 64'(cmd_index), 64'd0);
        check("rst_cmd_arg", 64'(cmd_arg), 64'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed frames
        run_cmd(48'h40_00000000_95, 1'b0, 32'h0, 1'b1, n);        // CMD0, silent
        run_cmd(48'h51_00000000_55, 1'b1, 32'h0, 1'b1, n);        // CMD17
        run_cmd(48'h48_000001AA_87, 1'b1, $urandom, 1'b1, n);     // CMD8
        run_cmd(48'h40_00000000_95, 1'b1, 32'h0, 1'b1, n);        // line 0x00_00000000_01
        run_cmd(48'h51_00000000_57, 1'b1, $urandom, 1'b1, n);     // bad CRC

        // Rejected frames, then a good one back-to-back
        run_raw(48'h3F_FF_FFFF_FFFF);                              // transmission bit 0
        repeat (2) @(negedge CLK) cmd_in = 1'b1;
        f = mk_cmd(6'd17, 32'h0000_1234);
        f[0] = 1'b0;
        run_raw(f);                                                // end bit 0
        run_cmd(mk_cmd(6'd55, 32'hDEAD_BEEF), 1'b1, $urandom, 1'b1, n);

        // Randomized commands
        for (int k = 0; k < 20; k++) begin
            f = mk_cmd(6'($urandom), $urandom);
            if ($urandom_range(0, 5) == 0) begin
                flip = 7'($urandom_range(1, 127));
                f[7:1] = f[7:1] ^ flip;
            end
            run_cmd(f, $urandom_range(0, 3) != 0, $urandom, 1'b1, n);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // Reset during response bit 20
        run_cmd(mk_cmd(6'd17, 32'h0000_0200), 1'b1, $urandom, 1'b0, n);
        @(negedge CLK) cmd_in = 1'b1;
        target = n + 1 + RD + 20;
        while (cyc < target) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("midtx_rst_cmd_oe", 64'(cmd_oe), 64'd0);
        check("midtx_rst_cmd_out", 64'(cmd_out), 64'd1);
        check("midtx_rst_cmd_index", 64'(cmd_index), 64'd0);
        check("midtx_rst_cmd_arg", 64'(cmd_arg), 64'd0);
        ev_q.delete();
        rsp_q.delete();
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        run_cmd(48'h51_00000000_55, 1'b1, $urandom, 1'b1, n);

        // Drain and confirm nothing outstanding
        repeat (10) @(negedge CLK);
        check("events_drained", 64'(ev_q.size()), 64'd0);
        check("responses_drained", 64'(rsp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
